// File: rtl/gen_csrcnt_pkg.sv
// Shared definitions for the counter-class CSRs: address map, default write
// masks and the rw/rs/rc new-value helper.
package gen_csrcnt_pkg;

    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MHPM3     = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHPM3H    = 12'hB83;

    localparam logic [63:0] WMASK_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] WMASK_NONE = 64'h0000_0000_0000_0000;

    // One bit of the CSR result; rc is implied when neither rw nor rs is set.
    function automatic logic csr_new_bit(input logic rw, input logic rs,
                                         input logic w, input logic op);
        logic r;
        if (rw) begin
            r = op;
        end else if (rs) begin
            r = w | op;
        end else begin
            r = w & ~op;
        end
        return r;
    endfunction

endpackage

// File: rtl/gen_csrcnt_if.sv
// Decoded CSR access bus shared by the registers of the CSR file.
interface gen_csrcnt_if #(
    parameter int DW = 64
);
    logic [DW-1:0] csr_op;
    logic [11:0]   addr;
    logic          rw;
    logic          rs;
    logic          rc;
    logic [DW-1:0] rdata;

    modport master (output csr_op, addr, rw, rs, rc, input rdata);
    modport slave  (input csr_op, addr, rw, rs, rc, output rdata);
endinterface

// File: rtl/gen_csrcnt_wsel.sv
// Word select and write-mask merge: next counter value for a CSR access to
// either the low word or the (zero-extended) high word.
module gen_csrcnt_wsel
    import gen_csrcnt_pkg::*;
#(
    parameter int DW = 64,
    parameter int CW = 64,
    parameter logic [CW-1:0] WMASK = {CW{1'b1}}
) (
    input  logic [CW-1:0] qout,
    input  logic [DW-1:0] csr_op,
    input  logic          hit_h,
    input  logic          rw,
    input  logic          rs,
    output logic [CW-1:0] next_q
);

    logic [2*DW-1:0] q_ext_s;
    logic [2*DW-1:0] m_ext_s;
    logic [2*DW-1:0] n_ext_s;
    logic [DW-1:0]   word_s;
    logic [DW-1:0]   mask_s;
    logic [DW-1:0]   merged_s;

    // Widen to two full words so bits above CW read as zero and are dropped on write-back.
    always_comb begin
        q_ext_s = {(2*DW){1'b0}};
        m_ext_s = {(2*DW){1'b0}};
        q_ext_s[CW-1:0] = qout;
        m_ext_s[CW-1:0] = WMASK;
        if (hit_h) begin
            word_s = q_ext_s[2*DW-1:DW];
            mask_s = m_ext_s[2*DW-1:DW];
        end else begin
            word_s = q_ext_s[DW-1:0];
            mask_s = m_ext_s[DW-1:0];
        end
        for (int i = 0; i < DW; i++) begin
            if (mask_s[i]) begin
                merged_s[i] = csr_new_bit(rw, rs, word_s[i], csr_op[i]);
            end else begin
                merged_s[i] = word_s[i];
            end
        end
        n_ext_s = q_ext_s;
        if (hit_h) begin
            n_ext_s[2*DW-1:DW] = merged_s;
        end else begin
            n_ext_s[DW-1:0] = merged_s;
        end
        next_q = n_ext_s[CW-1:0];
    end

endmodule

// File: rtl/gen_csrcnt.sv
// Counter-class CSR (mcycle/minstret/mhpmcounter): software access, hardware
// overwrite and increment, sticky overflow and illegal-op flag.
module gen_csrcnt
    import gen_csrcnt_pkg::*;
#(
    parameter int DW = 64,
    parameter int CW = 64,
    parameter int IW = 4,
    parameter logic [CW-1:0] rstValue = {CW{1'b0}},
    parameter logic [CW-1:0] WMASK    = {CW{1'b1}},
    parameter logic [11:0]   CSRADDR  = 12'h000,
    parameter logic [11:0]   CSRADDRH = 12'h000
) (
    input  logic          CLK,
    input  logic          RSTn,
    gen_csrcnt_if.slave   bus,
    input  logic [CW-1:0] privi_data,
    input  logic          isPrivi,
    input  logic [IW-1:0] inc,
    input  logic          inhibit,
    input  logic          ovf_clr,
    output logic [CW-1:0] qout,
    output logic          ovf_pend,
    output logic          op_err
);

    localparam logic HAS_HI = (CW > DW) ? 1'b1 : 1'b0;

    logic [CW-1:0]   qout_r;
    logic            ovf_pend_r;
    logic            op_err_r;
    logic            hit_l_s;
    logic            hit_h_s;
    logic            multi_s;
    logic            acc_s;
    logic            do_inc_s;
    logic            carry_s;
    logic [CW:0]     inc_ext_s;
    logic [CW:0]     sum_s;
    logic [CW-1:0]   csr_q_s;
    logic [CW-1:0]   next_q_s;
    logic [2*DW-1:0] rq_ext_s;

    assign hit_l_s  = (bus.addr == CSRADDR);
    assign hit_h_s  = HAS_HI & (bus.addr == CSRADDRH);
    assign multi_s  = (bus.rw & bus.rs) | (bus.rw & bus.rc) | (bus.rs & bus.rc);
    assign acc_s    = (hit_l_s | hit_h_s) & (bus.rw | bus.rs | bus.rc) & ~multi_s;
    assign do_inc_s = ~inhibit & (inc != {IW{1'b0}});
    assign sum_s    = {1'b0, qout_r} + inc_ext_s;
    assign carry_s  = do_inc_s & ~acc_s & ~isPrivi & sum_s[CW];

    gen_csrcnt_wsel #(
        .DW    (DW),
        .CW    (CW),
        .WMASK (WMASK)
    ) u_wsel (
        .qout   (qout_r),
        .csr_op (bus.csr_op),
        .hit_h  (hit_h_s),
        .rw     (bus.rw),
        .rs     (bus.rs),
        .next_q (csr_q_s)
    );

    // A legal CSR access to either half outranks privi, which outranks increment.
    always_comb begin
        inc_ext_s = {(CW+1){1'b0}};
        inc_ext_s[IW-1:0] = inc;
        if (acc_s) begin
            next_q_s = csr_q_s;
        end else if (isPrivi) begin
            next_q_s = privi_data;
        end else if (do_inc_s) begin
            next_q_s = sum_s[CW-1:0];
        end else begin
            next_q_s = qout_r;
        end
    end

    // Read mux on the pre-update value; high word is zero-extended.
    always_comb begin
        rq_ext_s = {(2*DW){1'b0}};
        rq_ext_s[CW-1:0] = qout_r;
        if (hit_l_s) begin
            bus.rdata = rq_ext_s[DW-1:0];
        end else if (hit_h_s) begin
            bus.rdata = rq_ext_s[2*DW-1:DW];
        end else begin
            bus.rdata = {DW{1'b0}};
        end
    end

    // Counter, sticky overflow (set beats clear) and one-cycle illegal-op flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            qout_r     <= rstValue;
            ovf_pend_r <= 1'b0;
            op_err_r   <= 1'b0;
        end else begin
            qout_r   <= next_q_s;
            op_err_r <= multi_s;
            if (carry_s) begin
                ovf_pend_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_pend_r <= 1'b0;
            end else begin
                ovf_pend_r <= ovf_pend_r;
            end
        end
    end

    assign qout     = qout_r;
    assign ovf_pend = ovf_pend_r;
    assign op_err   = op_err_r;

endmodule

// File: tb/tb_gen_csrcnt.sv
// Directed bench: a 32/64 split counter and a 32-bit masked counter.
module tb_gen_csrcnt;
    import gen_csrcnt_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [63:0] privi_a;
    logic        isprivi_a;
    logic [3:0]  inc_a;
    logic        inhibit_a;
    logic        ovf_clr_a;
    logic [63:0] qout_a;
    logic        ovf_a;
    logic        err_a;
    logic [31:0] privi_b;
    logic        isprivi_b;
    logic [3:0]  inc_b;
    logic        inhibit_b;
    logic        ovf_clr_b;
    logic [31:0] qout_b;
    logic        ovf_b;
    logic        err_b;

    int n_checks;
    int n_fail;

    gen_csrcnt_if #(.DW(32)) bus_a ();
    gen_csrcnt_if #(.DW(32)) bus_b ();

    gen_csrcnt #(
        .DW(32), .CW(64), .IW(4),
        .CSRADDR(CSR_MCYCLE), .CSRADDRH(CSR_MCYCLEH)
    ) u_dut_a (
        .CLK(clk), .RSTn(rst_n), .bus(bus_a),
        .privi_data(privi_a), .isPrivi(isprivi_a), .inc(inc_a),
        .inhibit(inhibit_a), .ovf_clr(ovf_clr_a),
        .qout(qout_a), .ovf_pend(ovf_a), .op_err(err_a)
    );

    gen_csrcnt #(
        .DW(32), .CW(32), .IW(4), .WMASK(32'h0000_00FF),
        .CSRADDR(CSR_MINSTRET), .CSRADDRH(CSR_MINSTRETH)
    ) u_dut_b (
        .CLK(clk), .RSTn(rst_n), .bus(bus_b),
        .privi_data(privi_b), .isPrivi(isprivi_b), .inc(inc_b),
        .inhibit(inhibit_b), .ovf_clr(ovf_clr_b),
        .qout(qout_b), .ovf_pend(ovf_b), .op_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        privi_a = 64'h0; isprivi_a = 1'b0; inc_a = 4'h0; inhibit_a = 1'b0; ovf_clr_a = 1'b0;
        privi_b = 32'h0; isprivi_b = 1'b0; inc_b = 4'h0; inhibit_b = 1'b0; ovf_clr_b = 1'b0;
        bus_a.csr_op = 32'h0; bus_a.addr = 12'h000; bus_a.rw = 1'b0; bus_a.rs = 1'b0; bus_a.rc = 1'b0;
        bus_b.csr_op = 32'h0; bus_b.addr = 12'h000; bus_b.rw = 1'b0; bus_b.rs = 1'b0; bus_b.rc = 1'b0;
        #12;
        check_eq("rst_qout", qout_a, 64'h0);
        check_eq("rst_ovf", {63'h0, ovf_a}, 64'h0);
        check_eq("rst_err", {63'h0, err_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain increment, then inhibit
        inc_a = 4'h1;
        repeat (10) tick();
        check_eq("inc10", qout_a, 64'd10);
        inhibit_a = 1'b1; inc_a = 4'h3;
        repeat (5) tick();
        check_eq("inhibit", qout_a, 64'd10);

        // High-word write beats increment
        inhibit_a = 1'b0; inc_a = 4'h1;
        bus_a.addr = CSR_MCYCLEH; bus_a.rw = 1'b1; bus_a.csr_op = 32'h1;
        tick();
        bus_a.rw = 1'b0; inc_a = 4'h0;
        check_eq("hi_write", qout_a, 64'h1_0000_000A);
        check_eq("rd_hi", {32'h0, bus_a.rdata}, 64'h1);
        bus_a.addr = CSR_MCYCLE;
        #1 check_eq("rd_lo", {32'h0, bus_a.rdata}, 64'hA);
        bus_a.addr = 12'h123;
        #1 check_eq("rd_miss", {32'h0, bus_a.rdata}, 64'h0);

        // Overflow set, clear, and set beating clear
        isprivi_a = 1'b1; privi_a = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        isprivi_a = 1'b0;
        check_eq("privi", qout_a, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("privi_no_ovf", {63'h0, ovf_a}, 64'h0);
        inc_a = 4'h3;
        tick();
        inc_a = 4'h0;
        check_eq("wrap", qout_a, 64'h1);
        check_eq("ovf_set", {63'h0, ovf_a}, 64'h1);
        ovf_clr_a = 1'b1;
        tick();
        ovf_clr_a = 1'b0;
        check_eq("ovf_clr", {63'h0, ovf_a}, 64'h0);
        isprivi_a = 1'b1;
        tick();
        isprivi_a = 1'b0; inc_a = 4'h3; ovf_clr_a = 1'b1;
        tick();
        inc_a = 4'h0; ovf_clr_a = 1'b0;
        check_eq("ovf_set_wins", {63'h0, ovf_a}, 64'h1);
        check_eq("wrap2", qout_a, 64'h1);

        // Illegal multi-op: no CSR write, increment proceeds, one-cycle flag
        bus_a.addr = CSR_MCYCLE; bus_a.rw = 1'b1; bus_a.rs = 1'b1; bus_a.csr_op = 32'h55; inc_a = 4'h2;
        tick();
        bus_a.rw = 1'b0; bus_a.rs = 1'b0; inc_a = 4'h0;
        check_eq("err_set", {63'h0, err_a}, 64'h1);
        check_eq("err_qout", qout_a, 64'h3);
        tick();
        check_eq("err_pulse", {63'h0, err_a}, 64'h0);
        check_eq("err_hold", qout_a, 64'h3);

        // Legal low write outranks privi and increment
        bus_a.rw = 1'b1; isprivi_a = 1'b1; privi_a = 64'h77; inc_a = 4'h1;
        tick();
        bus_a.rw = 1'b0; isprivi_a = 1'b0; inc_a = 4'h0;
        check_eq("csr_over_privi", qout_a, 64'h55);

        // Masked set/clear/write on the 32-bit counter
        isprivi_b = 1'b1; privi_b = 32'h1234;
        tick();
        isprivi_b = 1'b0;
        check_eq("b_privi", {32'h0, qout_b}, 64'h1234);
        bus_b.addr = CSR_MINSTRET; bus_b.csr_op = 32'hFFFF; bus_b.rs = 1'b1;
        tick();
        bus_b.rs = 1'b0;
        check_eq("b_rs", {32'h0, qout_b}, 64'h12FF);
        bus_b.rc = 1'b1;
        tick();
        bus_b.rc = 1'b0;
        check_eq("b_rc", {32'h0, qout_b}, 64'h1200);
        bus_b.rw = 1'b1; bus_b.csr_op = 32'hFFFF_FFFF;
        tick();
        bus_b.rw = 1'b0;
        check_eq("b_rw", {32'h0, qout_b}, 64'h12FF);
        check_eq("b_rd_lo", {32'h0, bus_b.rdata}, 64'h12FF);
        bus_b.addr = CSR_MINSTRETH;
        #1 check_eq("b_rd_no_hi", {32'h0, bus_b.rdata}, 64'h0);

        // Asynchronous reset mid-cycle
        isprivi_a = 1'b1; privi_a = 64'h40;
        tick();
        isprivi_a = 1'b0;
        check_eq("pre_rst_q", qout_a, 64'h40);
        check_eq("pre_rst_ovf", {63'h0, ovf_a}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_q", qout_a, 64'h0);
        check_eq("async_ovf", {63'h0, ovf_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gen_csrcnt.md
Name: gen_csrcnt

Overview:
Parametrised CSR counter register for mcycle/minstret/mhpmcounter-class CSRs.
- Adds the following to the plain CSR register: hardware increment, inhibit, per-bit write mask, split high/low addressing when XLEN < counter width, a sticky overflow-pending flag, and a registered illegal-op flag.
- Sits in the CSR file beside plain CSR registers. It is driven by the same decoded csr_op/addr/rw/rs/rc bus plus the privileged hardware-update path.

Parameters:
DW, 64, CSR data width (XLEN); legal values 32 or 64.
CW, 64, counter width; CW >= DW, CW <= 2*DW.
IW, 4, width of per-cycle increment amount.
rstValue, {CW{1'b0}}, counter reset value.
WMASK, {CW{1'b1}}, software-writable bits; a 0 bit is never changed by rw/rs/rc.
CSRADDR, 12'b0, address of low word (or full word when CW == DW).
CSRADDRH, 12'b0, address of high word; used only when CW > DW.

Ports:
CLK  input  1  clock
RSTn  input  1  asynchronous active-low reset
csr_op  input  DW  CSR instruction operand
addr  input  12  CSR address
rw  input  1  CSR write
rs  input  1  CSR set
rc  input  1  CSR clear
privi_data  input  CW  hardware overwrite value (full width)
isPrivi  input  1  hardware overwrite strobe
inc  input  IW  increment amount this cycle
inhibit  input  1  suppress increment (mcountinhibit bit)
ovf_clr  input  1  clear overflow-pending
rdata  output  DW  read data for matching address, else 0 (combinational)
qout  output  CW  full counter value (registered)
ovf_pend  output  1  sticky overflow flag (registered)
op_err  output  1  illegal multi-op flag (registered, one cycle)

Behaviour:
- Reset (RSTn low, asynchronous): qout = rstValue, ovf_pend = 0, op_err = 0. All updates are ignored while RSTn is low.
- hitL = (addr == CSRADDR). hitH = (CW > DW) & (addr == CSRADDRH). acc = (hitL | hitH) & (rw | rs | rc).
- Illegal op: more than one of rw/rs/rc asserted.
  - The next cycle op_err = 1; otherwise op_err = 0.
  - No CSR update is performed that cycle.
  - Increment and privi still proceed.
- Per-cycle update priority, highest first:
  1. Legal acc: CSR update.
  2. isPrivi: qout <= privi_data.
  3. !inhibit & inc != 0: qout <= qout + inc, modulo 2^CW.
  4. Otherwise hold.
- Any legal acc, to either half, suppresses both privi and increment in that cycle.
- CSR update:
  - Select the addressed word W: low = qout[DW-1:0]; high = qout[CW-1:DW], zero-extended to DW.
  - new = rw ? csr_op : rs ? (W | csr_op) : (W & ~csr_op).
  - Apply new only to bits where WMASK = 1 within the selected word. The other half of qout is unchanged.
  - High-half bits above CW-DW are discarded.
- Overflow:
  - Only increment can raise ovf. Carry-out of qout + inc beyond CW bits sets ovf_pend the same edge as the wrapped count update.
  - CSR and privi writes never set ovf_pend.
  - ovf_pend stays 1 until ovf_clr.
  - If a carry and ovf_clr occur in the same cycle, the set wins.
- rdata: hitL gives qout[DW-1:0]; hitH gives zero-extended qout[CW-1:DW]; otherwise 0. It reflects the pre-update value and is independent of rw/rs/rc.
- Latency: every update is visible on qout the cycle after the strobe.

Decomposition:
- A shared CSR package holds:
  - the CSR address constants for counters (mcycle/minstret/hpm low and high);
  - the op-select encoding helper (rw/rs/rc to new-value function);
  - default WMASK constants.
- One natural sub-module: gen_csrcnt_wsel, a combinational word-select and mask-merge that produces the next counter value from qout, csr_op, hitL/hitH and the op. The sequential register and the ovf/err flops stay in gen_csrcnt.

Test Plan:
- Reset then inc=1 for 10 cycles with inhibit=0 -> qout=10; assert inhibit with inc=3 for 5 cycles -> qout stays 10.
- DW=32, CW=64: rw to CSRADDRH with 0x1 while inc=1 -> next qout=0x1_0000_000A (low unchanged, no increment); read CSRADDRH -> rdata=0x1.
- privi_data=64'hFFFF_FFFF_FFFF_FFFE, then inc=3 -> qout=1, ovf_pend=1 next edge; ovf_clr alone -> ovf_pend=0; carry together with ovf_clr -> ovf_pend=1.
- WMASK=0x00FF, qout=0x1234: rs with csr_op=0xFFFF -> qout=0x12FF; rc with 0xFFFF -> qout=0x1200.
- rw=rs=1 at CSRADDR with csr_op=0x55 -> op_err=1 for exactly one cycle, qout unchanged by the CSR path and still incremented if inc!=0.
- Assert RSTn low mid-cycle while qout=0x40 and ovf_pend=1 -> qout=rstValue and ovf_pend=0 immediately, without waiting for a CLK edge.
